// File: rtl/hs_2_axi_if.sv
// Bundle of the request-side handshake and the AXI4-Lite master channels of the hs_2_axi bridge.
// Parameters:
//   ADDR_W - address width (hs_addr_i, araddr_o, awaddr_o)
//   DATA_W - data width; STRB_W = DATA_W/8 byte strobes
// Modports:
//   master - bridge view: samples hs_* requests and AXI responses, drives AXI requests
//            and handshake completion
//   slave  - environment view: requester plus AXI-Lite responder
interface hs_2_axi_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Handshake (requester) side
  logic              hs_read_i;
  logic              hs_write_i;
  logic [ADDR_W-1:0] hs_addr_i;
  logic [DATA_W-1:0] hs_data_i;
  logic [STRB_W-1:0] hs_byte_select_i;
  logic              hs_busy_o;
  logic              hs_ready_o;
  logic [DATA_W-1:0] hs_data_o;
  logic              hs_err_o;

  // AXI4-Lite read channels
  logic              arvalid_o;
  logic              arready_i;
  logic [ADDR_W-1:0] araddr_o;
  logic              rvalid_i;
  logic              rready_o;
  logic [DATA_W-1:0] rdata_i;
  logic [1:0]        rresp_i;

  // AXI4-Lite write channels
  logic              awvalid_o;
  logic              awready_i;
  logic [ADDR_W-1:0] awaddr_o;
  logic              wvalid_o;
  logic              wready_i;
  logic [DATA_W-1:0] wdata_o;
  logic [STRB_W-1:0] wstrb_o;
  logic              bvalid_i;
  logic              bready_o;
  logic [1:0]        bresp_i;

  modport master (
    input  hs_read_i, hs_write_i, hs_addr_i, hs_data_i, hs_byte_select_i,
    output hs_busy_o, hs_ready_o, hs_data_o, hs_err_o,
    output arvalid_o, araddr_o, rready_o,
    input  arready_i, rvalid_i, rdata_i, rresp_i,
    output awvalid_o, awaddr_o, wvalid_o, wdata_o, wstrb_o, bready_o,
    input  awready_i, wready_i, bvalid_i, bresp_i
  );

  modport slave (
    output hs_read_i, hs_write_i, hs_addr_i, hs_data_i, hs_byte_select_i,
    input  hs_busy_o, hs_ready_o, hs_data_o, hs_err_o,
    input  arvalid_o, araddr_o, rready_o,
    output arready_i, rvalid_i, rdata_i, rresp_i,
    input  awvalid_o, awaddr_o, wvalid_o, wdata_o, wstrb_o, bready_o,
    output awready_i, wready_i, bvalid_i, bresp_i
  );
endinterface

// File: rtl/hs_2_axi.sv
// Handshake-to-AXI4-Lite initiator bridge. Turns single-cycle hs_read_i/hs_write_i pulses into
// one AXI-Lite transaction at a time and reports completion with a one-cycle hs_ready_o pulse
// (read data on hs_data_o, slave error on hs_err_o).
// Ports:
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset; aborts any transaction in flight
//   bus   - hs_2_axi_if.master: handshake request/completion plus AR/R/AW/W/B channels
// Build option:
//   HS2AXI_SEQ_WRITE_EN - when defined, W is only raised the cycle after the AW handshake
//                         (address-first slaves); otherwise AW and W are issued together.
// All outputs are registered; no valid depends combinationally on a ready.
module hs_2_axi (
  input logic       clk_i,
  input logic       rst_i,
  hs_2_axi_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StDone
  } state_e;

  state_e state_q;
  logic   aw_done_q;
  logic   w_done_q;

  logic aw_hs;
  logic w_hs;
  logic aw_done_now;
  logic w_done_now;

  assign aw_hs       = bus.awvalid_o & bus.awready_i;
  assign w_hs        = bus.wvalid_o & bus.wready_i;
  // AW and W may finish in either order; remember the one that already went.
  assign aw_done_now = aw_done_q | aw_hs;
  assign w_done_now  = w_done_q | w_hs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      bus.hs_busy_o  <= 1'b0;
      bus.hs_ready_o <= 1'b0;
      bus.hs_data_o  <= '0;
      bus.hs_err_o   <= 1'b0;
      bus.arvalid_o  <= 1'b0;
      bus.araddr_o   <= '0;
      bus.rready_o   <= 1'b0;
      bus.awvalid_o  <= 1'b0;
      bus.awaddr_o   <= '0;
      bus.wvalid_o   <= 1'b0;
      bus.wdata_o    <= '0;
      bus.wstrb_o    <= '0;
      bus.bready_o   <= 1'b0;
    end else begin
      bus.hs_ready_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Write wins a simultaneous request; the read is dropped.
          if (bus.hs_write_i) begin
            state_q       <= StWrReq;
            bus.hs_busy_o <= 1'b1;
            bus.awaddr_o  <= bus.hs_addr_i;
            bus.wdata_o   <= bus.hs_data_i;
            bus.wstrb_o   <= bus.hs_byte_select_i;
            bus.awvalid_o <= 1'b1;
`ifdef HS2AXI_SEQ_WRITE_EN
            bus.wvalid_o  <= 1'b0;
`else
            bus.wvalid_o  <= 1'b1;
`endif
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
          end else if (bus.hs_read_i) begin
            state_q       <= StRdAddr;
            bus.hs_busy_o <= 1'b1;
            bus.araddr_o  <= bus.hs_addr_i;
            bus.arvalid_o <= 1'b1;
          end
        end
        StRdAddr: begin
          if (bus.arready_i) begin
            state_q       <= StRdData;
            bus.arvalid_o <= 1'b0;
            bus.rready_o  <= 1'b1;
          end
        end
        StRdData: begin
          if (bus.rvalid_i) begin
            state_q        <= StDone;
            bus.rready_o   <= 1'b0;
            bus.hs_data_o  <= bus.rdata_i;
            bus.hs_err_o   <= (bus.rresp_i != 2'b00);
            bus.hs_ready_o <= 1'b1;
          end
        end
        StWrReq: begin
          aw_done_q <= aw_done_now;
          w_done_q  <= w_done_now;
          if (aw_hs) begin
            bus.awvalid_o <= 1'b0;
`ifdef HS2AXI_SEQ_WRITE_EN
            bus.wvalid_o  <= 1'b1;
`endif
          end
          if (w_hs) begin
            bus.wvalid_o <= 1'b0;
          end
          if (aw_done_now && w_done_now) begin
            state_q      <= StWrResp;
            bus.bready_o <= 1'b1;
          end
        end
        StWrResp: begin
          if (bus.bvalid_i) begin
            state_q        <= StDone;
            bus.bready_o   <= 1'b0;
            bus.hs_err_o   <= (bus.bresp_i != 2'b00);
            bus.hs_ready_o <= 1'b1;
          end
        end
        StDone: begin
          // hs_ready_o is high this cycle; requests are taken again from the next one.
          state_q       <= StIdle;
          bus.hs_busy_o <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_2_axi.sv
// Directed self-checking bench for hs_2_axi: read, split-timing write, error response,
// request filtering while busy, reset abort. Works for both values of HS2AXI_SEQ_WRITE_EN.
module tb_hs_2_axi;

`ifdef HS2AXI_SEQ_WRITE_EN
  localparam bit Seq = 1'b1;
`else
  localparam bit Seq = 1'b0;
`endif
  // Zero-wait write latency, request cycle to hs_ready_o.
  localparam int WrLat = Seq ? 4 : 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hs_2_axi_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  hs_2_axi dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.hs_read_i        = 1'b0;
    bus.hs_write_i       = 1'b0;
    bus.hs_addr_i        = '0;
    bus.hs_data_i        = '0;
    bus.hs_byte_select_i = '0;
    bus.arready_i        = 1'b0;
    bus.rvalid_i         = 1'b0;
    bus.rdata_i          = '0;
    bus.rresp_i          = 2'b00;
    bus.awready_i        = 1'b0;
    bus.wready_i         = 1'b0;
    bus.bvalid_i         = 1'b0;
    bus.bresp_i          = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(bus.hs_busy_o), 32'd0);
    chk("rst_ready", 32'(bus.hs_ready_o), 32'd0);
    chk("rst_err", 32'(bus.hs_err_o), 32'd0);
    chk("rst_arvalid", 32'(bus.arvalid_o), 32'd0);
    chk("rst_awvalid", 32'(bus.awvalid_o), 32'd0);
    chk("rst_wvalid", 32'(bus.wvalid_o), 32'd0);
    chk("rst_rready", 32'(bus.rready_o), 32'd0);
    chk("rst_bready", 32'(bus.bready_o), 32'd0);
    chk("rst_hs_data", bus.hs_data_o, 32'd0);
    chk("rst_araddr", bus.araddr_o, 32'd0);
    rst = 1'b0;
    tick();

    // 1: read, arready immediately, R one cycle later
    bus.hs_read_i = 1'b1;
    bus.hs_addr_i = 32'h1000_0004;
    bus.arready_i = 1'b1;
    tick();                                    // T+1
    bus.hs_read_i = 1'b0;
    chk("rd_busy", 32'(bus.hs_busy_o), 32'd1);
    chk("rd_arvalid", 32'(bus.arvalid_o), 32'd1);
    chk("rd_araddr", bus.araddr_o, 32'h1000_0004);
    tick();                                    // T+2
    chk("rd_arvalid_drop", 32'(bus.arvalid_o), 32'd0);
    chk("rd_rready", 32'(bus.rready_o), 32'd1);
    bus.arready_i = 1'b0;
    bus.rvalid_i  = 1'b1;
    bus.rdata_i   = 32'hDEAD_BEEF;
    tick();                                    // T+3
    bus.rvalid_i = 1'b0;
    chk("rd_ready", 32'(bus.hs_ready_o), 32'd1);
    chk("rd_data", bus.hs_data_o, 32'hDEAD_BEEF);
    chk("rd_err", 32'(bus.hs_err_o), 32'd0);
    chk("rd_busy_done", 32'(bus.hs_busy_o), 32'd1);
    chk("rd_rready_drop", 32'(bus.rready_o), 32'd0);
    tick();
    chk("rd_ready_pulse", 32'(bus.hs_ready_o), 32'd0);
    chk("rd_busy_idle", 32'(bus.hs_busy_o), 32'd0);

    // 2: write, W ready first, AW ready three cycles later
    bus.hs_write_i       = 1'b1;
    bus.hs_addr_i        = 32'h1000_0000;
    bus.hs_data_i        = 32'h0000_00A5;
    bus.hs_byte_select_i = 4'b0001;
    tick();                                    // T+1
    bus.hs_write_i = 1'b0;
    bus.wready_i   = 1'b1;
    chk("wr_awvalid", 32'(bus.awvalid_o), 32'd1);
    chk("wr_wvalid", 32'(bus.wvalid_o), Seq ? 32'd0 : 32'd1);
    chk("wr_awaddr", bus.awaddr_o, 32'h1000_0000);
    chk("wr_wdata", bus.wdata_o, 32'h0000_00A5);
    chk("wr_wstrb", 32'(bus.wstrb_o), 32'h1);
    tick();                                    // T+2
    chk("wr_wvalid_t2", 32'(bus.wvalid_o), 32'd0);
    chk("wr_awvalid_t2", 32'(bus.awvalid_o), 32'd1);
    tick();                                    // T+3
    chk("wr_wvalid_t3", 32'(bus.wvalid_o), 32'd0);
    chk("wr_awvalid_t3", 32'(bus.awvalid_o), 32'd1);
    tick();                                    // T+4
    chk("wr_awvalid_t4", 32'(bus.awvalid_o), 32'd1);
    chk("wr_bready_t4", 32'(bus.bready_o), 32'd0);
    bus.awready_i = 1'b1;
    tick();                                    // T+5
    bus.awready_i = 1'b0;
    chk("wr_awvalid_drop", 32'(bus.awvalid_o), 32'd0);
    chk("wr_wvalid_t5", 32'(bus.wvalid_o), Seq ? 32'd1 : 32'd0);
    chk("wr_bready_t5", 32'(bus.bready_o), Seq ? 32'd0 : 32'd1);
    if (Seq) begin
      tick();                                  // W handshakes at this edge
      chk("wr_seq_wvalid_drop", 32'(bus.wvalid_o), 32'd0);
      chk("wr_seq_bready", 32'(bus.bready_o), 32'd1);
    end
    bus.wready_i = 1'b0;
    bus.bvalid_i = 1'b1;
    bus.bresp_i  = 2'b00;
    chk("wr_ready_before_b", 32'(bus.hs_ready_o), 32'd0);
    tick();
    bus.bvalid_i = 1'b0;
    chk("wr_ready", 32'(bus.hs_ready_o), 32'd1);
    chk("wr_err", 32'(bus.hs_err_o), 32'd0);
    chk("wr_hs_data_kept", bus.hs_data_o, 32'hDEAD_BEEF);
    chk("wr_bready_drop", 32'(bus.bready_o), 32'd0);
    tick();
    chk("wr_ready_pulse", 32'(bus.hs_ready_o), 32'd0);
    chk("wr_busy_idle", 32'(bus.hs_busy_o), 32'd0);

    // 3: zero-wait write with SLVERR, then OKAY read clears hs_err_o
    bus.hs_write_i       = 1'b1;
    bus.hs_addr_i        = 32'h0000_0020;
    bus.hs_data_i        = 32'h1234_5678;
    bus.hs_byte_select_i = 4'hF;
    bus.awready_i        = 1'b1;
    bus.wready_i         = 1'b1;
    bus.bvalid_i         = 1'b1;
    bus.bresp_i          = 2'b10;
    tick();
    bus.hs_write_i = 1'b0;
    for (int i = 1; i < WrLat; i++) begin
      chk("err_wr_early_ready", 32'(bus.hs_ready_o), 32'd0);
      tick();
    end
    chk("err_wr_ready", 32'(bus.hs_ready_o), 32'd1);
    chk("err_wr_err", 32'(bus.hs_err_o), 32'd1);
    idle_inputs();
    tick();
    bus.hs_read_i = 1'b1;
    bus.hs_addr_i = 32'h0000_0030;
    bus.arready_i = 1'b1;
    bus.rvalid_i  = 1'b1;
    bus.rdata_i   = 32'hCAFE_F00D;
    bus.rresp_i   = 2'b00;
    tick();                                    // T+1
    bus.hs_read_i = 1'b0;
    tick();                                    // T+2
    chk("err_rd_early_ready", 32'(bus.hs_ready_o), 32'd0);
    tick();                                    // T+3
    chk("err_rd_ready", 32'(bus.hs_ready_o), 32'd1);
    chk("err_rd_err", 32'(bus.hs_err_o), 32'd0);
    chk("err_rd_data", bus.hs_data_o, 32'hCAFE_F00D);
    idle_inputs();
    tick();

    // 4: simultaneous read+write performs write; requests while busy are ignored
    bus.hs_write_i       = 1'b1;
    bus.hs_read_i        = 1'b1;
    bus.hs_addr_i        = 32'h0000_0040;
    bus.hs_data_i        = 32'h0000_0055;
    bus.hs_byte_select_i = 4'b0011;
    bus.awready_i        = 1'b1;
    bus.wready_i         = 1'b1;
    bus.bvalid_i         = 1'b1;
    tick();                                    // T+1
    chk("both_awvalid", 32'(bus.awvalid_o), 32'd1);
    chk("both_arvalid", 32'(bus.arvalid_o), 32'd0);
    bus.hs_write_i = 1'b0;
    bus.hs_addr_i  = 32'h0000_0080;            // busy-time read request held high
    for (int i = 1; i < WrLat; i++) tick();
    chk("both_ready", 32'(bus.hs_ready_o), 32'd1);
    chk("both_busy_done", 32'(bus.hs_busy_o), 32'd1);
    idle_inputs();
    tick();
    chk("busy_req_arvalid", 32'(bus.arvalid_o), 32'd0);
    chk("busy_req_busy", 32'(bus.hs_busy_o), 32'd0);
    chk("busy_req_araddr", bus.araddr_o, 32'h0000_0030);
    chk("both_awaddr", bus.awaddr_o, 32'h0000_0040);
    chk("both_wstrb", 32'(bus.wstrb_o), 32'h3);
    tick();
    chk("busy_req_idle", 32'(bus.hs_busy_o), 32'd0);

    // 5: reset while arvalid_o is high and R is pending
    bus.hs_read_i = 1'b1;
    bus.hs_addr_i = 32'h0000_0050;
    tick();
    bus.hs_read_i = 1'b0;
    chk("rst_mid_arvalid", 32'(bus.arvalid_o), 32'd1);
    bus.rvalid_i = 1'b1;
    bus.rdata_i  = 32'h1111_2222;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rvalid_i = 1'b0;
    chk("abort_arvalid", 32'(bus.arvalid_o), 32'd0);
    chk("abort_rready", 32'(bus.rready_o), 32'd0);
    chk("abort_busy", 32'(bus.hs_busy_o), 32'd0);
    chk("abort_ready", 32'(bus.hs_ready_o), 32'd0);
    chk("abort_hs_data", bus.hs_data_o, 32'd0);
    chk("abort_araddr", bus.araddr_o, 32'd0);
    chk("abort_awaddr", bus.awaddr_o, 32'd0);
    chk("abort_wdata", bus.wdata_o, 32'd0);
    chk("abort_wstrb", 32'(bus.wstrb_o), 32'd0);
    tick();
    chk("abort_no_ready", 32'(bus.hs_ready_o), 32'd0);
    bus.hs_read_i = 1'b1;
    bus.hs_addr_i = 32'h0000_0060;
    bus.arready_i = 1'b1;
    bus.rvalid_i  = 1'b1;
    bus.rdata_i   = 32'h0BAD_F00D;
    bus.rresp_i   = 2'b00;
    tick();
    bus.hs_read_i = 1'b0;
    chk("post_rst_araddr", bus.araddr_o, 32'h0000_0060);
    tick();
    tick();
    chk("post_rst_ready", 32'(bus.hs_ready_o), 32'd1);
    chk("post_rst_data", bus.hs_data_o, 32'h0BAD_F00D);
    chk("post_rst_err", 32'(bus.hs_err_o), 32'd0);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
